// File: rtl/ring_osc_pkg.sv
// Shared state encoding and sizing helpers for the ring oscillator scheduler.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_e;

  // A single ring still needs a 1-bit index port.
  function automatic int idx_width(input int num_rings);
    return (num_rings > 1) ? $clog2(num_rings) : 1;
  endfunction

endpackage

// File: rtl/ring_edge_counter.sv
// Two-flop synchroniser, rising-edge detector and saturating edge counter
// for the currently selected ring oscillator output.
module ring_edge_counter #(
  parameter int CNT_W = 24
) (
  input  logic             fpga_clock,
  input  logic             rst,
  input  logic             ring_in,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise;

  // The synchroniser free-runs so the settle window flushes the previous
  // ring's samples; only the counter is held clear.
  always_comb begin
    sync1_d = ring_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (cnt_en && rise && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge fpga_clock) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = &count_q;

endmodule

// File: rtl/ring_osc_scheduler.sv
// Sweeps a bank of ring oscillators one at a time: settle, gated edge count,
// report, then on to the next enabled ring (optionally wrapping forever).
//
// state      | meaning
// ST_IDLE    | waiting for start with a non-zero mask
// ST_SETTLE  | ring enabled, SETTLE_CYCLES cycles, counter held clear
// ST_MEASURE | ring enabled, GATE_CYCLES cycles, edges counted
// ST_REPORT  | ring disabled, result captured, pick next ring or stop
module ring_osc_scheduler
  import ring_osc_pkg::*;
#(
  parameter int NUM_RINGS     = 3,
  parameter int GATE_CYCLES   = 133000,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 24,
  localparam int IDX_W        = idx_width(NUM_RINGS)
) (
  input  logic                 fpga_clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 stop,
  input  logic [NUM_RINGS-1:0] ring_mask,
  input  logic [NUM_RINGS-1:0] ring_out,
  output logic [NUM_RINGS-1:0] ring_en,
  output logic                 busy,
  output logic                 result_valid,
  output logic [IDX_W-1:0]     result_idx,
  output logic [CNT_W-1:0]     result_count,
  output logic                 result_sat
);

  localparam int GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [GATE_W-1:0]   GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_RINGS-1:0] mask_q, mask_d;
  logic                 cont_q, cont_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [GATE_W-1:0]    gate_q, gate_d;
  logic [NUM_RINGS-1:0] ring_en_q, ring_en_d;
  logic                 res_valid_q, res_valid_d;
  logic [IDX_W-1:0]     res_idx_q, res_idx_d;
  logic [CNT_W-1:0]     res_count_q, res_count_d;
  logic                 res_sat_q, res_sat_d;

  logic                 next_hit;
  logic [IDX_W-1:0]     next_idx, low_idx, start_idx;
  logic                 ring_sel;
  logic [CNT_W-1:0]     edge_count;
  logic                 edge_sat;

  // Mask walker: descending scan leaves the lowest qualifying index.
  always_comb begin
    next_hit  = 1'b0;
    next_idx  = '0;
    low_idx   = '0;
    start_idx = '0;
    for (int i = NUM_RINGS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_hit = 1'b1;
        next_idx = IDX_W'(i);
      end
      if (mask_q[i]) begin
        low_idx = IDX_W'(i);
      end
      if (ring_mask[i]) begin
        start_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ring_sel = 1'b0;
    for (int i = 0; i < NUM_RINGS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ring_sel = ring_out[i];
      end
    end
  end

  ring_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .fpga_clock (fpga_clock),
    .rst        (rst),
    .ring_in    (ring_sel),
    .clr        (state_q == ST_SETTLE),
    .cnt_en     (state_q == ST_MEASURE),
    .count      (edge_count),
    .sat        (edge_sat)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    cont_d      = cont_q;
    settle_d    = settle_q;
    gate_d      = gate_q;
    stop_pend_d = stop_pend_q | (stop && (state_q != ST_IDLE));
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_count_d = res_count_q;
    res_sat_d   = res_sat_q;
    ring_en_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && (|ring_mask)) begin
          state_d  = ST_SETTLE;
          mask_d   = ring_mask;
          cont_d   = continuous & ~stop;
          idx_d    = start_idx;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_MEASURE;
          gate_d  = GATE_LOAD;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_MEASURE: begin
        if (gate_q == '0) begin
          state_d = ST_REPORT;
        end else begin
          gate_d = gate_q - 1'b1;
        end
      end
      ST_REPORT: begin
        res_valid_d = 1'b1;
        res_idx_d   = idx_q;
        res_count_d = edge_count;
        res_sat_d   = edge_sat;
        if (next_hit) begin
          state_d  = ST_SETTLE;
          idx_d    = next_idx;
          settle_d = SETTLE_LOAD;
        end else if (cont_q && !stop_pend_q && !stop) begin
          state_d  = ST_SETTLE;
          idx_d    = low_idx;
          settle_d = SETTLE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      stop_pend_d = 1'b0;
    end

    // Enable follows the next state so it is a clean registered output.
    if ((state_d == ST_SETTLE) || (state_d == ST_MEASURE)) begin
      for (int i = 0; i < NUM_RINGS; i++) begin
        ring_en_d[i] = (idx_d == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge fpga_clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      settle_q    <= '0;
      gate_q      <= '0;
      ring_en_q   <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      settle_q    <= settle_d;
      gate_q      <= gate_d;
      ring_en_q   <= ring_en_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_count_q <= res_count_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign ring_en      = ring_en_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = res_valid_q;
  assign result_idx   = res_idx_q;
  assign result_count = res_count_q;
  assign result_sat   = res_sat_q;

endmodule

// File: tb/tb_ring_osc_scheduler.sv
// Bench for ring_osc_scheduler: behavioural rings with programmable period,
// table-driven sweeps, hand-written corner sequences and randomized sweeps.
module tb_ring_osc_scheduler;
  import ring_osc_pkg::*;

  localparam int NR     = 3;
  localparam int GATE   = 1000;
  localparam int SETTLE = 16;
  localparam int CW     = 8;
  localparam int SATV   = 255;
  localparam int SWEEP_BUDGET = 4 * (GATE + SETTLE + 4);

  logic          clk = 1'b0;
  logic          rst, start, continuous, stop;
  logic [NR-1:0] ring_mask, ring_out, ring_en;
  logic          busy, result_valid, result_sat;
  logic [1:0]    result_idx;
  logic [CW-1:0] result_count;

  int n_checks = 0;
  int n_pass   = 0;
  int base     = 0;
  int ring_per[NR] = '{10, 10, 10};

  typedef struct {
    int idx;
    int cnt;
    bit sat;
  } res_t;
  res_t got_q[$];
  res_t mon_r;

  typedef struct {
    logic [NR-1:0] mask;
    int            per[NR];
    int            n;
    int            ei[NR];
    int            ec[NR];
    bit            es[NR];
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ring_osc_scheduler #(
    .NUM_RINGS     (NR),
    .GATE_CYCLES   (GATE),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (CW)
  ) dut (
    .fpga_clock   (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .stop         (stop),
    .ring_mask    (ring_mask),
    .ring_out     (ring_out),
    .ring_en      (ring_en),
    .busy         (busy),
    .result_valid (result_valid),
    .result_idx   (result_idx),
    .result_count (result_count),
    .result_sat   (result_sat)
  );

  // Ring model: toggles every half period while enabled, parked low otherwise.
  // Offsets keep every toggle off the clock edges.
  for (genvar g = 0; g < NR; g++) begin : g_ring
    logic r = 1'b0;
    initial begin
      #(g + 1);
      forever begin
        #(ring_per[g] * 5);
        r = ring_en[g] ? ~r : 1'b0;
      end
    end
    assign ring_out[g] = r;
  end

  always @(negedge clk) begin
    if (result_valid) begin
      mon_r.idx = int'(result_idx);
      mon_r.cnt = int'(result_count);
      mon_r.sat = result_sat;
      got_q.push_back(mon_r);
    end
  end

  // Invariant monitor; results are folded into counted checks at the end.
  int inv_err = 0, win_seen = 0, win_bad = 0, mlen = 0;
  int abort_req = 0, abort_done = 0;
  always @(negedge clk) begin
    if (!$onehot0(ring_en) ||
        (((dut.state_q == ST_IDLE) || (dut.state_q == ST_REPORT)) && (ring_en != '0))) begin
      inv_err++;
      if (inv_err <= 5) $display("FAIL ring_en invariant: got %b at %0t", ring_en, $time);
    end
    if (dut.state_q == ST_MEASURE) begin
      mlen++;
    end else if (mlen != 0) begin
      if (abort_req > abort_done) begin
        abort_done++;
      end else begin
        win_seen++;
        if (mlen != GATE) begin
          win_bad++;
          $display("FAIL measure window: got %0d cycles expected %0d", mlen, GATE);
        end
      end
      mlen = 0;
    end
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (busy && (c < budget)) begin
      @(negedge clk);
      c++;
    end
    check(!busy, {tag, " returns to idle"}, int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_sweep(input logic [NR-1:0] m, input bit c, input string tag);
    logic [NR-1:0] first;
    base = got_q.size();
    first = m & (~m + 1'b1);
    @(negedge clk);
    start = 1'b1; ring_mask = m; continuous = c;
    @(negedge clk);
    start = 1'b0; ring_mask = '0; continuous = 1'b0;
    check(busy == 1'b1, {tag, " busy after start"}, int'(busy), 1);
    check(ring_en == first, {tag, " first ring_en"}, int'(ring_en), int'(first));
    wait_idle(SWEEP_BUDGET, tag);
  endtask

  task automatic check_res(input int k, input int ei, input int ec, input bit es, input string tag);
    check(got_q.size() > k, {tag, " result present"}, got_q.size(), k + 1);
    if (got_q.size() > k) begin
      res_t r;
      r = got_q[k];
      check(r.idx == ei, {tag, " idx"}, r.idx, ei);
      if (ec >= SATV) check(r.cnt == SATV, {tag, " count"}, r.cnt, SATV);
      else check((r.cnt >= ec - 1) && (r.cnt <= ec + 1), {tag, " count"}, r.cnt, ec);
      check(r.sat == es, {tag, " sat"}, int'(r.sat), int'(es));
    end
  endtask

  // Reference: edges in the gate lie between floor and ceil of GATE/period,
  // widened by one for synchroniser phase, then clipped at the counter ceiling.
  task automatic check_model(input int k, input int ring, input string tag);
    int p, lo, hi;
    p  = ring_per[ring];
    lo = GATE / p - 1;
    hi = (GATE + p - 1) / p + 1;
    if (lo > SATV) lo = SATV;
    if (hi > SATV) hi = SATV;
    check(got_q.size() > k, {tag, " result present"}, got_q.size(), k + 1);
    if (got_q.size() > k) begin
      res_t r;
      r = got_q[k];
      check(r.idx == ring, {tag, " idx"}, r.idx, ring);
      check((r.cnt >= lo) && (r.cnt <= hi), {tag, " count"}, r.cnt, GATE / p);
      if (lo >= SATV) check(r.sat == 1'b1, {tag, " sat"}, int'(r.sat), 1);
      else if (hi < SATV) check(r.sat == 1'b0, {tag, " sat"}, int'(r.sat), 0);
    end
  endtask

  task automatic add_vec(input logic [NR-1:0] m, input int p0, input int p1, input int p2,
                         input int n, input int i0, input int c0, input bit s0,
                         input int i1, input int c1, input bit s1,
                         input int i2, input int c2, input bit s2);
    vec_t v;
    v.mask = m;
    v.per[0] = p0; v.per[1] = p1; v.per[2] = p2;
    v.n = n;
    v.ei[0] = i0; v.ec[0] = c0; v.es[0] = s0;
    v.ei[1] = i1; v.ec[1] = c1; v.es[1] = s1;
    v.ei[2] = i2; v.ec[2] = c2; v.es[2] = s2;
    vecs.push_back(v);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0; ring_mask = '0;

    add_vec(3'b111, 10, 20, 40, 3, 0, 100, 0, 1,  50, 0, 2, 25, 0);
    add_vec(3'b010,  8,  8,  8, 1, 1, 125, 0, 0,   0, 0, 0,  0, 0);
    add_vec(3'b100, 10, 10,  2, 1, 2, 255, 1, 0,   0, 0, 0,  0, 0);
    add_vec(3'b011,  3,  4, 10, 2, 0, 255, 1, 1, 250, 0, 0,  0, 0);
    add_vec(3'b101, 50, 10, 25, 2, 0,  20, 0, 2,  40, 0, 0,  0, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check(ring_en == '0, "reset ring_en", int'(ring_en), 0);
    check(busy == 1'b0, "reset busy", int'(busy), 0);
    check(result_valid == 1'b0, "reset result_valid", int'(result_valid), 0);
    check(result_idx == '0, "reset result_idx", int'(result_idx), 0);
    check(result_count == '0, "reset result_count", int'(result_count), 0);
    check(result_sat == 1'b0, "reset result_sat", int'(result_sat), 0);

    foreach (vecs[v]) begin
      for (int g = 0; g < NR; g++) ring_per[g] = vecs[v].per[g];
      do_sweep(vecs[v].mask, 1'b0, $sformatf("vec%0d", v));
      check(got_q.size() - base == vecs[v].n, $sformatf("vec%0d n results", v),
            got_q.size() - base, vecs[v].n);
      for (int k = 0; k < vecs[v].n; k++)
        check_res(base + k, vecs[v].ei[k], vecs[v].ec[k], vecs[v].es[k], $sformatf("vec%0d r%0d", v, k));
    end

    // Continuous sweep of 101, stop during ring 0's gate: ring 2 still runs, no wrap.
    ring_per[0] = 10; ring_per[1] = 10; ring_per[2] = 20;
    base = got_q.size();
    @(negedge clk); start = 1'b1; ring_mask = 3'b101; continuous = 1'b1;
    @(negedge clk); start = 1'b0; ring_mask = '0; continuous = 1'b0;
    repeat (SETTLE + 300) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(SWEEP_BUDGET, "cont stop");
    check(got_q.size() - base == 2, "cont stop n results", got_q.size() - base, 2);
    check_res(base, 0, 100, 0, "cont stop r0");
    check_res(base + 1, 2, 50, 0, "cont stop r1");

    // Continuous 011 wraps to ring 0 once; stop in the second pass ends after ring 1.
    ring_per[0] = 10; ring_per[1] = 20;
    base = got_q.size();
    @(negedge clk); start = 1'b1; ring_mask = 3'b011; continuous = 1'b1;
    @(negedge clk); start = 1'b0; ring_mask = '0; continuous = 1'b0;
    c = 0;
    while ((got_q.size() - base < 2) && (c < SWEEP_BUDGET)) begin
      @(negedge clk);
      c++;
    end
    check(got_q.size() - base >= 2, "wrap first pass", got_q.size() - base, 2);
    repeat (SETTLE + 100) @(negedge clk);
    check(busy == 1'b1, "wrap busy in second pass", int'(busy), 1);
    check(ring_en == 3'b001, "wrap revisits ring 0", int'(ring_en), 1);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(SWEEP_BUDGET, "wrap");
    check(got_q.size() - base == 4, "wrap n results", got_q.size() - base, 4);
    check_res(base,     0, 100, 0, "wrap r0");
    check_res(base + 1, 1,  50, 0, "wrap r1");
    check_res(base + 2, 0, 100, 0, "wrap r2");
    check_res(base + 3, 1,  50, 0, "wrap r3");

    // start and stop together: continuous is dropped, a single pass runs.
    base = got_q.size();
    @(negedge clk); start = 1'b1; stop = 1'b1; ring_mask = 3'b010; continuous = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0; ring_mask = '0; continuous = 1'b0;
    wait_idle(SWEEP_BUDGET, "start+stop");
    check(got_q.size() - base == 1, "start+stop n results", got_q.size() - base, 1);
    check_res(base, 1, 50, 0, "start+stop r0");

    // Reset in the middle of a gate.
    ring_per[0] = 10;
    base = got_q.size();
    @(negedge clk); start = 1'b1; ring_mask = 3'b001;
    @(negedge clk); start = 1'b0; ring_mask = '0;
    repeat (SETTLE + 200) @(negedge clk);
    abort_req++;
    rst = 1'b1;
    @(negedge clk);
    check(ring_en == '0, "mid reset ring_en", int'(ring_en), 0);
    check(busy == 1'b0, "mid reset busy", int'(busy), 0);
    rst = 1'b0;
    repeat (GATE + 50) @(negedge clk);
    check(got_q.size() == base, "mid reset no result", got_q.size() - base, 0);
    check(result_count == '0, "mid reset result_count", int'(result_count), 0);
    do_sweep(3'b001, 1'b0, "after reset");
    check_res(base, 0, 100, 0, "after reset r0");

    // Ignored starts: empty mask in idle, and any start while busy.
    base = got_q.size();
    @(negedge clk); start = 1'b1; ring_mask = '0;
    @(negedge clk); start = 1'b0;
    check(busy == 1'b0, "empty mask busy", int'(busy), 0);
    check(ring_en == '0, "empty mask ring_en", int'(ring_en), 0);
    repeat (5) @(negedge clk);
    check(result_idx == 2'd0, "empty mask result_idx held", int'(result_idx), 0);
    check((result_count >= 99) && (result_count <= 101), "empty mask result_count held",
          int'(result_count), 100);
    check(got_q.size() == base, "empty mask no result", got_q.size() - base, 0);
    @(negedge clk); start = 1'b1; ring_mask = 3'b001;
    @(negedge clk); start = 1'b0; ring_mask = '0;
    repeat (50) @(negedge clk);
    start = 1'b1; ring_mask = 3'b110; continuous = 1'b1;
    @(negedge clk); start = 1'b0; ring_mask = '0; continuous = 1'b0;
    check(ring_en == 3'b001, "busy start ring_en", int'(ring_en), 1);
    wait_idle(SWEEP_BUDGET, "busy start");
    check(got_q.size() - base == 1, "busy start n results", got_q.size() - base, 1);
    check_res(base, 0, 100, 0, "busy start r0");

    // Randomized single sweeps against the reference model.
    for (int it = 0; it < 8; it++) begin
      logic [NR-1:0] m;
      int k;
      m = NR'($urandom_range(1, 7));
      for (int g = 0; g < NR; g++) ring_per[g] = $urandom_range(3, 40);
      do_sweep(m, 1'b0, $sformatf("rand%0d", it));
      k = 0;
      for (int g = 0; g < NR; g++) begin
        if (m[g]) begin
          check_model(base + k, g, $sformatf("rand%0d r%0d", it, k));
          k++;
        end
      end
      check(got_q.size() - base == k, $sformatf("rand%0d n results", it), got_q.size() - base, k);
    end

    check(inv_err == 0, "ring_en invariant violations", inv_err, 0);
    check(win_bad == 0, "measure window violations", win_bad, 0);
    check(win_seen > 20, "measure windows observed", win_seen, 21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
